jtgng_objdraw: RTL



---
 rtl/jtgng_objdraw.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jtgng_objdraw.sv
// rtl/jtgng_objdraw.sv - per-line object drawer from slot buffer through object ROM into the line buffer
// Scans the buffered slots after each HINIT, fetches two graphics words per visible slot and writes its opaque pixels.
`timescale 1ns/1ps
module jtgng_objdraw #(
   parameter int         ROM_AW    = 15,
   parameter int         OBJ_SLOTS = 32,
   parameter logic [7:0] EMPTY_Y   = 8'hF8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen6,
   input  logic              HINIT,
   input  logic [7:0]        VF,
   input  logic [7:0]        objbuf_data,
   output logic [4:0]        objcnt,
   output logic [3:0]        pxlcnt,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_cs,
   input  logic              rom_ok,
   input  logic [31:0]       rom_data,
   output logic [8:0]        buf_addr,
   output logic [7:0]        buf_data,
   output logic              buf_we,
   output logic              done
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_ROM, S_DRAW, S_NEXT} state_t;

   state_t              r_state, w_next;
   logic [4:0]          r_objcnt;
   logic [1:0]          r_pxlcnt;
   logic [2:0]          r_rdcnt;
   logic [7:0]          r_code_lo, r_attr, r_y, r_x;
   logic [3:0]          r_row;
   logic                r_h;
   logic [2:0]          r_pix;
   logic [31:0]         r_pixels;
   logic                r_rom_cs, r_buf_we, r_done;
   logic [ROM_AW-1:0]   r_rom_addr;
   logic [8:0]          r_buf_addr;
   logic [7:0]          r_buf_data;

   logic                w_start, w_hit, w_hflip;
   logic [7:0]          w_d;
   logic [3:0]          w_row, w_pal, w_p;
   logic [9:0]          w_code;
   logic [2:0]          w_sel;
   logic [8:0]          w_pos;

   assign w_start = cen6 & HINIT;
   assign w_d     = VF - r_y;
   assign w_hit   = (r_y != EMPTY_Y) && (w_d[7:4] == 4'd0);
   assign w_hflip = r_attr[2];
   assign w_row   = r_attr[3] ? ~w_d[3:0] : w_d[3:0];
   assign w_code  = {r_attr[7:6], r_code_lo};
   assign w_pal   = {1'b0, r_attr[1], r_attr[5:4]};
   // With hflip the word is read from its last pixel backwards.
   assign w_sel   = w_hflip ? ~r_pix : r_pix;
   assign w_p     = r_pixels[{w_sel, 2'b00} +: 4];
   assign w_pos   = {r_attr[0], r_x} + {5'd0, r_h, r_pix};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_start) begin
         w_next = S_READ;
      end else begin
         case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_READ:  if (cen6 && r_rdcnt == 3'd4) w_next = S_CHECK;
            S_CHECK: w_next = w_hit ? S_ROM : S_NEXT;
            S_ROM:   if (rom_ok) w_next = S_DRAW;
            S_DRAW:  if (r_pix == 3'd7) w_next = r_h ? S_NEXT : S_ROM;
            S_NEXT:  w_next = (r_objcnt == 5'(OBJ_SLOTS - 1)) ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_objcnt   <= 5'd0;
         r_pxlcnt   <= 2'd0;
         r_rdcnt    <= 3'd0;
         r_code_lo  <= 8'd0;
         r_attr     <= 8'd0;
         r_y        <= 8'd0;
         r_x        <= 8'd0;
         r_row      <= 4'd0;
         r_h        <= 1'b0;
         r_pix      <= 3'd0;
         r_pixels   <= 32'd0;
         r_rom_cs   <= 1'b0;
         r_rom_addr <= '0;
         r_buf_we   <= 1'b0;
         r_buf_addr <= 9'd0;
         r_buf_data <= 8'd0;
         r_done     <= 1'b1;
      end else begin
         r_buf_we <= 1'b0;
         if (w_start) begin
            r_objcnt <= 5'd0;
            r_pxlcnt <= 2'd0;
            r_rdcnt  <= 3'd0;
            r_rom_cs <= 1'b0;
            r_done   <= 1'b0;
         end else begin
            case (r_state)
               S_READ: if (cen6) begin
                  // Slot RAM data lags its address by one cen6, so byte k lands at count k+1.
                  case (r_rdcnt)
                     3'd1:    r_code_lo <= objbuf_data;
                     3'd2:    r_attr    <= objbuf_data;
                     3'd3:    r_y       <= objbuf_data;
                     3'd4:    r_x       <= objbuf_data;
                     default: ;
                  endcase
                  if (r_rdcnt == 3'd4) begin
                     r_rdcnt  <= 3'd0;
                     r_pxlcnt <= 2'd0;
                  end else begin
                     r_rdcnt <= r_rdcnt + 3'd1;
                     if (r_pxlcnt != 2'd3) r_pxlcnt <= r_pxlcnt + 2'd1;
                  end
               end
               S_CHECK: begin
                  r_row <= w_row;
                  r_h   <= 1'b0;
                  if (w_hit) begin
                     r_rom_cs   <= 1'b1;
                     r_rom_addr <= ROM_AW'({w_code, w_row, w_hflip});
                  end
               end
               S_ROM: if (rom_ok) begin
                  r_rom_cs <= 1'b0;
                  r_pixels <= rom_data;
                  r_pix    <= 3'd0;
               end
               S_DRAW: begin
                  r_buf_we   <= (w_p != 4'hF) && !w_pos[8];
                  r_buf_addr <= w_pos;
                  r_buf_data <= {w_pal, w_p};
                  r_pix      <= r_pix + 3'd1;
                  if (r_pix == 3'd7 && !r_h) begin
                     r_h        <= 1'b1;
                     r_rom_cs   <= 1'b1;
                     r_rom_addr <= ROM_AW'({w_code, r_row, ~w_hflip});
                  end
               end
               S_NEXT: begin
                  if (r_objcnt == 5'(OBJ_SLOTS - 1)) begin
                     r_done <= 1'b1;
                  end else begin
                     r_objcnt <= r_objcnt + 5'd1;
                     r_pxlcnt <= 2'd0;
                     r_rdcnt  <= 3'd0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign objcnt   = r_objcnt;
   assign pxlcnt   = {2'b00, r_pxlcnt};
   assign rom_addr = r_rom_addr;
   assign rom_cs   = r_rom_cs;
   assign buf_addr = r_buf_addr;
   assign buf_data = r_buf_data;
   assign buf_we   = r_buf_we;
   assign done     = r_done;
endmodule
